core_out_drain: RTL and testbench

Output drain stage directly downstream of the core's PSUM memory read port. Captures each `bw_psum*col`-bit output row presented with `out_valid` into a small row FIFO. Serializes each row into `col` single-column words on a narrow valid/ready bus toward the host or testbench collector. The core's output has no backpressure, so overflow is flagged rather than stalled.

---
 rtl/core_out_drain.sv | 152 +++++++++++++++
 tb/tb_core_out_drain.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_out_drain.sv
// Output drain: buffers PSUM rows from the core in a small FIFO and serializes
// each row into per-column words on a valid/ready bus. The core cannot be
// stalled, so a row arriving while the FIFO is full is dropped and flagged.
module core_out_drain #(
  parameter int unsigned col     = 8,
  parameter int unsigned bw_psum = 20,
  parameter int unsigned aw      = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [bw_psum*col-1:0] in,
  input  logic                   in_valid,
  output logic [bw_psum-1:0]     dout,
  output logic [2:0]             dout_col,
  output logic [7:0]             dout_row,
  output logic                   dout_last,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [aw:0]            count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow
);

  localparam int unsigned Depth = 2 ** aw;
  localparam int unsigned RowW  = bw_psum * col;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e            state_q, state_d;
  logic [RowW-1:0]   mem [Depth];
  logic [aw-1:0]     wr_ptr_q, wr_ptr_d;
  logic [aw-1:0]     rd_ptr_q, rd_ptr_d;
  logic [aw:0]       count_q, count_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [2:0]        col_q, col_d;
  logic [7:0]        dout_row_q, dout_row_d;
  logic [7:0]        row_num_q, row_num_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              pop, wr_en, drop, last;

  assign empty      = (count_q == '0);
  assign full       = (count_q == (aw+1)'(Depth));
  assign count      = count_q;
  assign last       = (col_q == 3'(col - 1));
  assign dout_col   = col_q;
  assign dout_row   = dout_row_q;
  assign dout_last  = last;
  assign dout_valid = valid_q;
  assign overflow   = ovf_q;

  // Serializer FSM: load a row when one is available, step columns on handshake
  always_comb begin
    pop        = 1'b0;
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    dout_row_d = dout_row_q;
    row_num_d  = row_num_q;
    valid_d    = valid_q;
    unique case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        if (dout_ready) begin
          if (!last) begin
            col_d = col_q + 3'd1;
          end else if (!empty) begin
            pop = 1'b1;  // back-to-back rows, no bubble
          end else begin
            valid_d = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      row_d      = mem[rd_ptr_q];
      col_d      = 3'd0;
      dout_row_d = row_num_q;
      row_num_d  = row_num_q + 8'd1;
      valid_d    = 1'b1;
    end
  end

  // FIFO bookkeeping: a pop frees a slot in the same cycle, so full+pop still writes
  always_comb begin
    wr_en    = in_valid && (!full || pop);
    drop     = in_valid && full && !pop;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_d    = ovf_q || drop;
    count_d  = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + (aw+1)'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - (aw+1)'(1);
    end
  end

  // Column word select from the held row
  always_comb begin
    dout = '0;
    for (int unsigned c = 0; c < col; c++) begin
      if (col_q == 3'(c)) begin
        dout = row_q[c*bw_psum +: bw_psum];
      end
    end
  end

  // Row storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= in;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      row_q      <= '0;
      col_q      <= '0;
      dout_row_q <= '0;
      row_num_q  <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      row_q      <= row_d;
      col_q      <= col_d;
      dout_row_q <= dout_row_d;
      row_num_q  <= row_num_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_core_out_drain.sv
// Scoreboard bench for core_out_drain: stimulus pushes expected words, a
// negedge monitor pops and compares every handshaken word.
module tb_core_out_drain;

  localparam int unsigned Col = 8;
  localparam int unsigned Bw  = 20;
  localparam int unsigned Aw  = 3;

  typedef struct packed {
    logic [19:0] d;
    logic [2:0]  c;
    logic [7:0]  r;
    logic        l;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [Bw*Col-1:0] in = '0;
  logic              in_valid = 1'b0;
  logic [Bw-1:0]     dout;
  logic [2:0]        dout_col;
  logic [7:0]        dout_row;
  logic              dout_last;
  logic              dout_valid;
  logic              dout_ready = 1'b0;
  logic [Aw:0]       count;
  logic              empty;
  logic              full;
  logic              overflow;

  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  int   vcyc   = 0;
  int   peak   = 0;
  logic [7:0] exp_row = '0;
  exp_t q[$];

  core_out_drain #(.col(Col), .bw_psum(Bw), .aw(Aw)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .in         (in),
    .in_valid   (in_valid),
    .dout       (dout),
    .dout_col   (dout_col),
    .dout_row   (dout_row),
    .dout_last  (dout_last),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [Bw*Col-1:0] mk_row(input int base);
    logic [Bw*Col-1:0] r;
    r = '0;
    for (int c = 0; c < Col; c++) r[c*Bw +: Bw] = 20'(base + c + 1);
    return r;
  endfunction

  task automatic push_row(input int base);
    exp_t e;
    for (int c = 0; c < Col; c++) begin
      e.d = 20'(base + c + 1);
      e.c = 3'(c);
      e.r = exp_row;
      e.l = (c == Col - 1);
      q.push_back(e);
    end
    exp_row = exp_row + 8'd1;
  endtask

  // One clock, then settle away from the edge and record activity
  task automatic step();
    @(posedge clk);
    #1;
    if (dout_valid) vcyc++;
    if (int'(count) > peak) peak = int'(count);
  endtask

  task automatic present(input int base, input bit accepted);
    in       = mk_row(base);
    in_valid = 1'b1;
    if (accepted) push_row(base);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    dout_ready = 1'b0;
    in         = '0;
    q.delete();
    exp_row = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    vcyc  = 0;
    peak  = 0;
  endtask

  task automatic drain(input string name, input int bound, input bit toggle);
    logic [3:0] pat;
    int n;
    pat = 4'b1001;
    n   = 0;
    while ((q.size() != 0 || dout_valid) && n < bound) begin
      if (toggle) dout_ready = pat[n % 4];
      step();
      n++;
    end
    if (n >= bound) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got %0d words pending required 0", name, q.size());
    end
  endtask

  // Monitor: scoreboard compare on handshake, stability check while stalled
  initial begin
    exp_t e;
    logic [31:0] held;
    bit stall;
    stall = 0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 0;
      end else begin
        if (stall) begin
          chk("stall_valid", 64'(dout_valid), 64'd1);
          chk("stall_hold", 64'({dout, dout_col, dout_row, dout_last}), 64'(held));
        end
        if (dout_valid && dout_ready) begin
          hs_cnt++;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word got 0x%0h required none", dout);
          end else begin
            e = q.pop_front();
            chk("word", 64'({dout, dout_col, dout_row, dout_last}), 64'(e));
          end
        end
        stall = dout_valid && !dout_ready;
        held  = {dout, dout_col, dout_row, dout_last};
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_hs;
    int n;

    // Reset values
    do_reset();
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_last", 64'(dout_last), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_colrow", 64'({dout_col, dout_row}), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_flags", 64'({empty, full, overflow}), 64'b100);

    // Single row, 2-cycle latency
    dout_ready = 1'b1;
    present(0, 1);
    step();
    in_valid = 1'b0;
    chk("single_count_after_write", 64'(count), 64'd1);
    chk("single_valid_lat1", 64'(dout_valid), 64'd0);
    step();
    chk("single_valid_lat2", 64'(dout_valid), 64'd1);
    chk("single_first_word", 64'({dout, dout_col, dout_row}), 64'({20'h00001, 3'd0, 8'd0}));
    chk("single_count_after_pop", 64'(count), 64'd0);
    drain("single", 40, 0);
    step();
    chk("single_end_valid", 64'(dout_valid), 64'd0);
    chk("single_end_empty", 64'(empty), 64'd1);

    // Backpressure with ready 1,0,0,1
    do_reset();
    base_hs = hs_cnt;
    present('h1000, 1);
    step();
    in_valid = 1'b0;
    drain("bp", 80, 1);
    chk("bp_handshakes", 64'(hs_cnt - base_hs), 64'd8);

    // Three rows back-to-back
    do_reset();
    dout_ready = 1'b1;
    base_hs = hs_cnt;
    for (int i = 0; i < 3; i++) begin
      present('h2000 + i * 'h10, 1);
      step();
    end
    in_valid = 1'b0;
    drain("b2b", 60, 0);
    chk("b2b_handshakes", 64'(hs_cnt - base_hs), 64'd24);
    chk("b2b_no_bubble", 64'(vcyc), 64'd24);
    chk("b2b_peak_count", 64'(peak), 64'd2);

    // Overflow: ten rows while stalled
    do_reset();
    base_hs = hs_cnt;
    for (int i = 0; i < 10; i++) begin
      present('h3000 + i * 'h10, i < 9);
      step();
      if (i == 8) begin
        chk("ovf_count_full", 64'(count), 64'd8);
        chk("ovf_full", 64'(full), 64'd1);
        chk("ovf_not_yet", 64'(overflow), 64'd0);
      end
    end
    in_valid = 1'b0;
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_count_kept", 64'(count), 64'd8);
    dout_ready = 1'b1;
    drain("ovf", 120, 0);
    chk("ovf_rows_drained", 64'(hs_cnt - base_hs), 64'd72);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Full FIFO with a write in the pop cycle
    do_reset();
    for (int i = 0; i < 9; i++) begin
      present('h4000 + i * 'h10, 1);
      step();
    end
    in_valid = 1'b0;
    chk("fp_count_pre", 64'(count), 64'd8);
    dout_ready = 1'b1;
    n = 0;
    while (dout_col != 3'd7 && n < 20) begin
      step();
      n++;
    end
    chk("fp_reached_last", 64'(dout_col), 64'd7);
    present('h4900, 1);
    step();
    in_valid = 1'b0;
    chk("fp_count_same", 64'(count), 64'd8);
    chk("fp_no_overflow", 64'(overflow), 64'd0);
    drain("fp", 200, 0);

    // Reset mid-row with two rows queued
    do_reset();
    dout_ready = 1'b1;
    base_hs = hs_cnt;
    for (int i = 0; i < 3; i++) begin
      present('h5000 + i * 'h10, 1);
      step();
    end
    in_valid = 1'b0;
    n = 0;
    while (hs_cnt - base_hs < 3 && n < 20) begin
      step();
      n++;
    end
    chk("mid_col_before", 64'(dout_col), 64'd3);
    chk("mid_count_before", 64'(count), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(dout_valid), 64'd0);
    chk("mid_rst_outs", 64'({dout, dout_col, dout_row, dout_last}), 64'd0);
    chk("mid_rst_flags", 64'({count, empty, full, overflow}), 64'b0000_100);
    do_reset();
    dout_ready = 1'b1;
    present('h6000, 1);
    step();
    in_valid = 1'b0;
    step();
    chk("mid_restart", 64'({dout_valid, dout_col, dout_row}), 64'({1'b1, 3'd0, 8'd0}));
    drain("mid", 40, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
